mvu_apb_master: RTL
===================

MVU_APB_MASTER -- requirements
Module: mvu_apb_master

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 2, meaning the command FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum ACCESS cycles without pready; 0 disables the timeout.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  a command is offered.
REQ-007 cmd_ready  output  1  the command FIFO can accept a command.
REQ-008 cmd_write  input  1  1 = APB write, 0 = APB read.
REQ-009 cmd_idx  input  12  MVU CSR index.
REQ-010 cmd_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  a completion is pending.
REQ-012 rsp_ready  input  1  the consumer takes the completion.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and for errors.
REQ-014 rsp_err  output  1  pslverr or timeout occurred.
REQ-015 paddr  output  32  APB byte address.
REQ-016 psel  output  1  APB select.
REQ-017 penable  output  1  APB enable.
REQ-018 pwrite  output  1  APB direction.
REQ-019 pwdata  output  32  APB write data.
REQ-020 pprot  output  3  constant 3'b000.
REQ-021 pstrb  output  4  constant 4'b1111.
REQ-022 prdata  input  32  APB read data.
REQ-023 pready  input  1  APB ready.
REQ-024 pslverr  input  1  APB error.

Function
REQ-025 A command SHALL be pushed when cmd_valid&&cmd_ready; cmd_ready SHALL be !full, with no bypass path, and commands SHALL be issued in FIFO order.
REQ-026 paddr SHALL be {16'b0, cmd_idx, 4'b0000}, so that MVU CSR index N maps to paddr[15:4]=N.
REQ-027 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-028 IDLE: if the FIFO is non-empty, pop the head into the transfer register and go to SETUP; otherwise stay in IDLE.
REQ-029 SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
REQ-030 ACCESS: psel=1, penable=1.
  - If pready: capture rsp_rdata (prdata for reads, 0 for writes) and rsp_err=pslverr, then go to RESP.
  - Else: increment the wait counter.
  - If the counter reaches TIMEOUT (and TIMEOUT≠0): rsp_err=1, rsp_rdata=0, go to RESP.
REQ-031 RESP: psel=penable=0 and rsp_valid=1 until rsp_ready.
  - On handshake with the FIFO non-empty: pop and go directly to SETUP.
  - On handshake with the FIFO empty: go to IDLE.
REQ-032 paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle and SHALL hold their last value outside transfers.
REQ-033 Latency: a command accepted at edge N into an idle, empty block SHALL produce SETUP in cycle N+2, and rsp_valid one cycle after the pready cycle.
REQ-034 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, cleared on entry to SETUP, and SHALL never wrap.
REQ-035 At most one APB transfer and one completion SHALL be outstanding; with rsp_ready low, no new SETUP SHALL start.

Reset
REQ-036 While rst is asserted, psel, penable, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, pwdata and the counter SHALL be 0, state SHALL be IDLE, the FIFO SHALL be emptied and cmd_ready SHALL be 0.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer immediately and discard all queued commands; cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-038 The state typedef (mvu_apb_mst_state_t) and the CSR index shift constant (4) SHALL live in apb_pkg.
REQ-039 The command FIFO SHALL be the sub-module mvu_apb_cmd_fifo ({write, idx, wdata}, 45 bits wide, CMD_DEPTH deep).

Verification
REQ-040 Write idx 0x012, wdata 0xDEADBEEF, pready=1 -> paddr=0x00000120, pwrite=1, 1 SETUP + 1 ACCESS cycle, rsp_err=0, rsp_rdata=0.
REQ-041 Read idx 0x003, pready after 3 wait cycles with prdata=0x000000A5 -> ACCESS lasts 4 cycles, rsp_rdata=0x000000A5.
REQ-042 Write with pready=1 and pslverr=1 -> rsp_err=1, rsp_rdata=0.
REQ-043 TIMEOUT=4, pready held 0 -> 4 ACCESS cycles, then psel drops, rsp_err=1, rsp_rdata=0.
REQ-044 Four back-to-back commands with rsp_ready=0 (CMD_DEPTH=2) -> one APB transfer, cmd_ready low after 3 acceptances; raising rsp_ready drains the commands in order with no idle cycle between RESP and SETUP.
REQ-045 rst asserted during ACCESS -> psel, penable and rsp_valid are 0 in the same cycle, and no APB activity occurs after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the MVU APB master: FSM state encoding,
// command record layout and the CSR-index-to-byte-address mapping.
package apb_pkg;

  typedef logic [1:0] mvu_apb_mst_state_t;

  localparam mvu_apb_mst_state_t ST_IDLE   = 2'd0;
  localparam mvu_apb_mst_state_t ST_SETUP  = 2'd1;
  localparam mvu_apb_mst_state_t ST_ACCESS = 2'd2;
  localparam mvu_apb_mst_state_t ST_RESP   = 2'd3;

  // Each MVU CSR occupies a 16-byte slot, so index N lands at paddr[15:4].
  localparam int unsigned CSR_IDX_SHIFT = 4;

  typedef struct packed {
    logic        write;
    logic [11:0] idx;
    logic [31:0] wdata;
  } mvu_apb_cmd_t;

  localparam int unsigned CMD_W = $bits(mvu_apb_cmd_t);

  function automatic logic [31:0] csr_addr(input logic [11:0] idx);
    return 32'(idx) << CSR_IDX_SHIFT;
  endfunction

endpackage

// File: rtl/mvu_apb_cmd_fifo.sv
// Command FIFO for the MVU APB master; power-of-two depth, no bypass path.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mvu_apb_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mvu_apb_master.sv
// Queued APB master for MVU CSR access: commands pass through a small FIFO,
// run one APB transfer at a time and complete through a rsp valid/ready port.
module mvu_apb_master
  import apb_pkg::*;
#(
  parameter int CMD_DEPTH = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_idx,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [2:0]  pprot,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mvu_apb_mst_state_t state;
  logic [CNT_W-1:0]   wait_cnt;
  mvu_apb_cmd_t       cmd_in;
  mvu_apb_cmd_t       fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               timeout_hit;

  assign cmd_in    = '{write: cmd_write, idx: cmd_idx, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full && !rst;

  // The head is consumed exactly when a new transfer is launched.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));

  // This is the last permitted ACCESS cycle; pready still wins if it arrives now.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  mvu_apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (!fifo_empty) state <= ST_SETUP;
        ST_SETUP:  state <= ST_ACCESS;
        ST_ACCESS: if (pready || timeout_hit) state <= ST_RESP;
        ST_RESP:   if (rsp_ready) state <= fifo_empty ? ST_IDLE : ST_SETUP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        paddr    <= csr_addr(fifo_head.idx);
        pwrite   <= fifo_head.write;
        pwdata   <= fifo_head.wdata;
        wait_cnt <= '0;
      end else if (state == ST_ACCESS && !pready && wait_cnt != {CNT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == ST_ACCESS) begin
        if (pready) begin
          rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
          rsp_err   <= pslverr;
        end else if (timeout_hit) begin
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

  assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);
  assign pprot     = 3'b000;
  assign pstrb     = 4'b1111;

endmodule
